// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types for the master interface and the slave-side register blocks.
package axi4lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      M_IDLE    = 3'd0,
      M_WR_REQ  = 3'd1,
      M_WR_RESP = 3'd2,
      M_RD_REQ  = 3'd3,
      M_RD_DATA = 3'd4,
      M_RSP     = 3'd5
   } master_state_t;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   // A watchdog expiry is reported with the same code as a decode error.
   localparam resp_t RESP_TIMEOUT = RESP_DECERR;

endpackage

// File: rtl/axi4lite_master_interface.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction, one response out.
// Optional watchdog enabled by defining AXI4LITE_MASTER_TIMEOUT_EN.
module axi4lite_master_interface
   import axi4lite_pkg::*;
#(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 11,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,

   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic                              rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,

   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,

   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int SW = DW / 8;

   // Clears the byte-lane bits so every access is aligned to the bus width.
   localparam logic [AW-1:0] ADDR_MASK = ~AW'(SW - 1);

   master_state_t    state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [SW-1:0]    wstrb_q, wstrb_d;
   logic             awvalid_q, awvalid_d;
   logic             wvalid_q, wvalid_d;
   logic             rsp_write_q, rsp_write_d;
   logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
   resp_t            rsp_resp_q, rsp_resp_d;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             busy;
`endif

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q     <= M_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         cnt_q         <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign busy = (state_q == M_WR_REQ) || (state_q == M_WR_RESP) ||
                 (state_q == M_RD_REQ) || (state_q == M_RD_DATA);
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = '0;
`endif

      case (state_q)
         M_IDLE: begin
            if (cmd_valid) begin
               addr_d      = cmd_addr & ADDR_MASK;
               wdata_d     = cmd_write ? cmd_wdata : '0;
               wstrb_d     = cmd_write ? cmd_wstrb : '0;
               rsp_write_d = cmd_write;
               rsp_rdata_d = '0;
               rsp_resp_d  = RESP_OKAY;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = M_WR_REQ;
               end else begin
                  state_d   = M_RD_REQ;
               end
            end
         end

         // AW and W complete independently; leave once neither is still pending.
         M_WR_REQ: begin
            if (awvalid_q && M_AXI_AWREADY) begin
               awvalid_d = 1'b0;
            end
            if (wvalid_q && M_AXI_WREADY) begin
               wvalid_d = 1'b0;
            end
            if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
               state_d = M_WR_RESP;
            end
         end

         M_WR_RESP: begin
            if (M_AXI_BVALID) begin
               rsp_resp_d = resp_t'(M_AXI_BRESP);
               state_d    = M_RSP;
            end
         end

         M_RD_REQ: begin
            if (M_AXI_ARREADY) begin
               state_d = M_RD_DATA;
            end
         end

         M_RD_DATA: begin
            if (M_AXI_RVALID) begin
               rsp_rdata_d = M_AXI_RDATA;
               rsp_resp_d  = resp_t'(M_AXI_RRESP);
               state_d     = M_RSP;
            end
         end

         M_RSP: begin
            if (rsp_ready) begin
               state_d = M_IDLE;
            end
         end

         default: begin
            state_d   = M_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
         end
      endcase

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      // A real slave response in the expiry cycle wins over the watchdog.
      if (busy && (state_d == state_q)) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_TIMEOUT;
            rsp_timeout_d = 1'b1;
            state_d       = M_RSP;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   assign cmd_ready     = (state_q == M_IDLE) && M_AXI_ARESETN;

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = (state_q == M_WR_RESP);

   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
   assign M_AXI_ARVALID = (state_q == M_RD_REQ);
   assign M_AXI_RREADY  = (state_q == M_RD_DATA);

   assign rsp_valid     = (state_q == M_RSP);
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
   assign rsp_timeout   = rsp_timeout_q;
`else
   assign rsp_timeout   = 1'b0;
`endif

endmodule
